sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM controller between two requesters: master 0 (instruction side) and master 1 (data side, MEM stage).
- Grants one master at a time with round-robin priority and forwards its request to the SRAM controller.
- Holds the request until the controller's ready, then returns read data plus a one-cycle ready pulse to the granted master; the ungranted master sees ready low and stays frozen.
- Includes a watchdog that flags a controller which never answers.

Parameters:
- ADDR_W, 32, request address width
- WDATA_W, 32, write data width
- RDATA_W, 64, read data width (one SRAM line)
- TIMEOUT, 63, max BUSY cycles before err is raised; counter width is clog2(TIMEOUT+1)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_rd_en, m1_rd_en  in  1  read request
- m0_wr_en, m1_wr_en  in  1  write request
- m0_miss, m1_miss  in  1  cache-miss qualifier, forwarded
- m0_addr, m1_addr  in  ADDR_W  byte address
- m0_wdata, m1_wdata  in  WDATA_W  write data
- m0_rdata, m1_rdata  out  RDATA_W  read data
- m0_ready, m1_ready  out  1  transaction-complete pulse
- mem_rd_en, mem_wr_en, mem_miss  out  1  to SRAM controller
- mem_addr  out  ADDR_W  to SRAM controller
- mem_wdata  out  WDATA_W  to SRAM controller
- mem_rdata  in  RDATA_W  from SRAM controller
- mem_ready  in  1  from SRAM controller
- grant  out  1  index of the owning master, valid while busy
- err  out  1  sticky watchdog timeout

Behaviour:
- Request rule: master N requests when rd_en or wr_en is high. Both high at once is illegal; the arbiter forwards both and does not correct it.
- Reset values: all outputs 0, state IDLE, priority pointer 0, watchdog 0, err 0. A reset asserted mid-transaction aborts it in the same edge, with no ready pulse.
- State IDLE:
  - If exactly one master requests, latch its index into grant and go to BUSY next cycle.
  - If both request, grant the master the pointer names.
  - No request: stay in IDLE; mem_* enables are low.
- State BUSY:
  - mem_* is a combinational mux of the granted master's live signals.
  - The master must hold its request stable until its ready pulse. A master that drops its request while in BUSY gets no ready; the arbiter returns to IDLE next cycle.
  - The watchdog increments each cycle. Reaching TIMEOUT sets err (sticky until rst) and returns to IDLE without a ready.
  - On mem_ready=1, register mem_rdata into the granted master's rdata and go to DONE.
- State DONE (exactly one cycle):
  - Granted master's ready=1; mem enables low so the SRAM controller returns to its idle state.
  - Pointer is set to the other master; watchdog clears; next state IDLE.
- Latency:
  - Request seen in cycle t, so BUSY starts at t+1.
  - mem_ready in cycle t+k, so ready pulses at t+k+1.
  - Minimum grant-to-grant spacing is 3 cycles (IDLE, BUSY, DONE).
- Output rules:
  - Each mN_rdata holds its last captured value until the next completion for that master.
  - Ungranted master's ready is always 0.
  - m0_ready and m1_ready are never high in the same cycle.
  - grant is 0 in IDLE.
- Fairness: with both masters requesting continuously, grants alternate strictly, so neither waits more than one foreign transaction.
- mem_ready while in IDLE or DONE is ignored.

Decomposition:
- Shared package holds:
  - state encoding ST_IDLE=2'b00, ST_BUSY=2'b01, ST_DONE=2'b10
  - master indices M_IF=0, M_MEM=1
  - default TIMEOUT
- One natural sub-module: rr_arbiter2, a 2-input round-robin picker. It takes req[1:0], pointer and an advance strobe, and returns a one-hot grant plus the next pointer. It is purely combinational except for the pointer register.

Test Plan:
- Single read, latency 5:
  - Stimulus: only m1 read, addr=0x0000_0104; mem_ready high 5 cycles after BUSY entry; mem_rdata=0xDEAD_BEEF_0123_4567.
  - Required: m1_ready pulses once, 6 cycles after the request; m1_rdata=0xDEAD_BEEF_0123_4567; m0_ready stays 0.
- Simultaneous requests after reset:
  - Stimulus: m0 read 0x10 and m1 write 0x20 both asserted in the same cycle after reset.
  - Required: grant=0 first, mem_addr=0x10; after m0_ready, grant=1, mem_wr_en=1, mem_addr=0x20; then m1_ready.
- Continuous contention:
  - Stimulus: both masters request continuously for 6 transactions.
  - Required: grant order 0,1,0,1,0,1; no ready pulse in two consecutive cycles for the same master.
- Timeout:
  - Stimulus: TIMEOUT=8; m0 read; mem_ready held 0.
  - Required: err=1 after 8 BUSY cycles; m0_ready never pulses; state back to IDLE; err stays 1 until rst.
- Reset mid-transaction:
  - Stimulus: rst asserted in BUSY while mem_ready=1 in the same cycle.
  - Required: next cycle all outputs 0, no ready pulse, pointer 0.
- Dropped request:
  - Stimulus: m1 deasserts wr_en during BUSY.
  - Required: mem_wr_en drops in the same cycle; IDLE next cycle; m1_ready stays 0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the two-master SRAM arbiter.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic M_IF  = 1'b0;
  localparam logic M_MEM = 1'b1;

  localparam int DEFAULT_TIMEOUT = 63;

  typedef struct packed {
    state_t state;
    logic   ptr;
    logic   ptr_next;
  } dbg_t;

endpackage

// File: rtl/sram_arbiter_rr.sv
// Two-input round-robin picker: combinational grant, registered priority pointer.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       owner,
  output logic [1:0] gnt_oh,
  output logic       ptr,
  output logic       ptr_next
);

  always_comb begin
    gnt_oh = req;
    if (req == 2'b11) begin
      gnt_oh = ptr ? 2'b10 : 2'b01;
    end
  end

  // On completion the pointer favours whoever did not just own the bus.
  assign ptr_next = advance ? ~owner : ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller between the instruction (m0) and data (m1) masters,
// with round-robin priority and a sticky watchdog on unanswered requests.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int WDATA_W = 32,
  parameter int RDATA_W = 64,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m0_rd_en,
  input  logic               m0_wr_en,
  input  logic               m0_miss,
  input  logic [ADDR_W-1:0]  m0_addr,
  input  logic [WDATA_W-1:0] m0_wdata,
  output logic [RDATA_W-1:0] m0_rdata,
  output logic               m0_ready,
  input  logic               m1_rd_en,
  input  logic               m1_wr_en,
  input  logic               m1_miss,
  input  logic [ADDR_W-1:0]  m1_addr,
  input  logic [WDATA_W-1:0] m1_wdata,
  output logic [RDATA_W-1:0] m1_rdata,
  output logic               m1_ready,
  output logic               mem_rd_en,
  output logic               mem_wr_en,
  output logic               mem_miss,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [WDATA_W-1:0] mem_wdata,
  input  logic [RDATA_W-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               grant,
  output logic               err,
  output dbg_t               dbg
);

  // Handshake: a master requests with rd_en|wr_en and must hold it stable until
  // its one-cycle mN_ready strobe; dropping it early abandons the transaction.
  // mem_ready is honoured only in BUSY, and mem_* enables are low outside BUSY.

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);

  state_t        state, state_n;
  logic          grant_q, grant_n;
  logic [CW-1:0] wdog, wdog_n;
  logic          err_set, capture, advance, req_g;
  logic [1:0]    req, gnt_oh;
  logic          ptr, ptr_next;

  assign req = {m1_rd_en | m1_wr_en, m0_rd_en | m0_wr_en};

  rr_arbiter2 u_rr (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .advance  (advance),
    .owner    (grant_q),
    .gnt_oh   (gnt_oh),
    .ptr      (ptr),
    .ptr_next (ptr_next)
  );

  always_comb begin
    state_n   = state;
    grant_n   = grant_q;
    wdog_n    = '0;
    err_set   = 1'b0;
    capture   = 1'b0;
    advance   = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_miss  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    req_g     = (grant_q == M_MEM) ? req[1] : req[0];
    case (state)
      ST_IDLE: begin
        if (|gnt_oh) begin
          state_n = ST_BUSY;
          grant_n = gnt_oh[1];
        end
      end
      ST_BUSY: begin
        if (grant_q == M_MEM) begin
          mem_rd_en = m1_rd_en;
          mem_wr_en = m1_wr_en;
          mem_miss  = m1_miss;
          mem_addr  = m1_addr;
          mem_wdata = m1_wdata;
        end else begin
          mem_rd_en = m0_rd_en;
          mem_wr_en = m0_wr_en;
          mem_miss  = m0_miss;
          mem_addr  = m0_addr;
          mem_wdata = m0_wdata;
        end
        wdog_n = wdog + CW'(1);
        if (!req_g) begin
          state_n = ST_IDLE;
        end else if (mem_ready) begin
          capture = 1'b1;
          state_n = ST_DONE;
        end else if (wdog == WD_LAST) begin
          err_set = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DONE: begin
        advance = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
    if (state_n != ST_BUSY) begin
      wdog_n = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      grant_q  <= 1'b0;
      wdog     <= '0;
      err      <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state   <= state_n;
      grant_q <= grant_n;
      wdog    <= wdog_n;
      if (err_set) begin
        err <= 1'b1;
      end
      if (capture) begin
        if (grant_q == M_MEM) begin
          m1_rdata <= mem_rdata;
        end else begin
          m0_rdata <= mem_rdata;
        end
      end
    end
  end

  assign m0_ready = (state == ST_DONE) && (grant_q == M_IF);
  assign m1_ready = (state == ST_DONE) && (grant_q == M_MEM);
  assign grant    = (state != ST_IDLE) ? grant_q : 1'b0;
  assign dbg      = '{state: state, ptr: ptr, ptr_next: ptr_next};

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: vector table plus hand-written corner sequences.
module tb_sram_arbiter;
  import sram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_rd_en, m0_wr_en, m0_miss, m1_rd_en, m1_wr_en, m1_miss;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [63:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        mem_rd_en, mem_wr_en, mem_miss, mem_ready;
  logic [31:0] mem_addr, mem_wdata;
  logic [63:0] mem_rdata;
  logic        grant, err;
  dbg_t        dbg;

  int checks = 0;
  int failures = 0;
  logic [63:0] exp0_q[$];
  logic [63:0] exp1_q[$];

  sram_arbiter #(.ADDR_W(32), .WDATA_W(32), .RDATA_W(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_en(m0_rd_en), .m0_wr_en(m0_wr_en), .m0_miss(m0_miss), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_rd_en(m1_rd_en), .m1_wr_en(m1_wr_en), .m1_miss(m1_miss), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_miss(mem_miss),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .grant(grant), .err(err), .dbg(dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_rd_en = 0; m0_wr_en = 0; m0_miss = 0; m0_addr = 0; m0_wdata = 0;
    m1_rd_en = 0; m1_wr_en = 0; m1_miss = 0; m1_addr = 0; m1_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // driver: answer the current BUSY transaction after lat cycles; ends in DONE
  task automatic serve(input int lat, input logic [63:0] rd, input logic m);
    for (int i = 1; i < lat; i++) tick();
    mem_ready = 1;
    mem_rdata = rd;
    if (m) exp1_q.push_back(rd);
    else exp0_q.push_back(rd);
    tick();
    mem_ready = 0;
    mem_rdata = {$urandom, $urandom};
  endtask

  // scoreboard: every ready pulse pops and compares the expected read data
  logic prev0 = 0, prev1 = 0;
  initial begin
    forever begin
      @(negedge clk);
      if (m0_ready && m1_ready) chk("both_ready", {m1_ready, m0_ready}, 2'b00);
      if (m0_ready) begin
        if (exp0_q.size() == 0) chk("m0_ready_unexpected", m0_ready, 1'b0);
        else chk("m0_rdata", m0_rdata, exp0_q.pop_front());
        chk("m0_ready_consecutive", prev0, 1'b0);
      end
      if (m1_ready) begin
        if (exp1_q.size() == 0) chk("m1_ready_unexpected", m1_ready, 1'b0);
        else chk("m1_rdata", m1_rdata, exp1_q.pop_front());
        chk("m1_ready_consecutive", prev1, 1'b0);
      end
      prev0 = m0_ready;
      prev1 = m1_ready;
    end
  end

  typedef struct {
    logic m0_rd, m0_wr, m0_ms, m1_rd, m1_wr, m1_ms;
    logic [31:0] m0_a, m1_a, m0_wd, m1_wd;
    int lat;
    logic [63:0] rdata;
    logic exp_g, exp_rd, exp_wr, exp_ms;
    logic [31:0] exp_a, exp_wd;
  } vec_t;

  vec_t vec[6];
  logic eg;
  logic [63:0] r;

  initial begin
    // pointer starts at 0 after reset and flips to the other master after each completion
    vec[0] = '{0,0,0, 1,0,1, 32'h0, 32'h200, 32'h0, 32'h0, 2, 64'h1111_0000_0000_0001, 1, 1,0,1, 32'h200, 32'h0};
    vec[1] = '{1,0,0, 1,0,0, 32'h300, 32'h400, 32'h0, 32'h0, 1, 64'h2222_0000_0000_0002, 0, 1,0,0, 32'h300, 32'h0};
    vec[2] = '{0,1,0, 1,0,0, 32'h500, 32'h600, 32'h1111_2222, 32'h0, 3, 64'h3333_0000_0000_0003, 1, 1,0,0, 32'h600, 32'h0};
    vec[3] = '{0,1,1, 0,0,0, 32'h700, 32'h0, 32'h3333_4444, 32'h0, 4, 64'h4444_0000_0000_0004, 0, 0,1,1, 32'h700, 32'h3333_4444};
    vec[4] = '{1,0,0, 0,0,0, 32'h800, 32'h0, 32'h0, 32'h0, 2, 64'h5555_0000_0000_0005, 0, 1,0,0, 32'h800, 32'h0};
    vec[5] = '{1,0,0, 0,1,1, 32'h900, 32'hA00, 32'h0, 32'h5555_6666, 6, 64'h6666_0000_0000_0006, 1, 0,1,1, 32'hA00, 32'h5555_6666};

    do_reset();
    @(negedge clk);
    chk("rst_grant", grant, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", {m1_ready, m0_ready}, 0);
    chk("rst_mem_en", {mem_rd_en, mem_wr_en, mem_miss}, 0);
    chk("rst_rdata", {m0_rdata ^ m1_rdata}, 0);
    chk("rst_state", dbg.state, ST_IDLE);
    chk("rst_ptr", dbg.ptr, 0);

    // single m1 read, k=5
    tick();
    m1_rd_en = 1; m1_addr = 32'h0000_0104;
    for (int c = 1; c <= 7; c++) begin
      tick();
      if (c == 5) begin
        mem_ready = 1; mem_rdata = 64'hDEAD_BEEF_0123_4567;
        exp1_q.push_back(64'hDEAD_BEEF_0123_4567);
      end else begin
        mem_ready = 0;
      end
      if (c == 6) m1_rd_en = 0;
      @(negedge clk);
      chk($sformatf("single_m1_ready_c%0d", c), m1_ready, (c == 6));
      chk($sformatf("single_m0_ready_c%0d", c), m0_ready, 0);
      chk($sformatf("single_mem_rd_c%0d", c), mem_rd_en, (c <= 5));
      if (c == 1) begin
        chk("single_grant", grant, 1);
        chk("single_addr", mem_addr, 32'h104);
      end
    end
    chk("single_rdata_hold", m1_rdata, 64'hDEAD_BEEF_0123_4567);

    // simultaneous requests after reset
    do_reset();
    m0_rd_en = 1; m0_addr = 32'h10;
    m1_wr_en = 1; m1_addr = 32'h20; m1_wdata = 32'hCAFE_F00D;
    tick();
    @(negedge clk);
    chk("sim_grant0", grant, 0);
    chk("sim_addr0", mem_addr, 32'h10);
    chk("sim_en0", {mem_rd_en, mem_wr_en}, 2'b10);
    serve(1, 64'hA5A5_0000_1234_0000, 0);
    m0_rd_en = 0;
    @(negedge clk);
    chk("sim_m0_ready", m0_ready, 1);
    tick();
    @(negedge clk);
    chk("sim_idle_gap", dbg.state, ST_IDLE);
    tick();
    @(negedge clk);
    chk("sim_grant1", grant, 1);
    chk("sim_addr1", mem_addr, 32'h20);
    chk("sim_wdata1", mem_wdata, 32'hCAFE_F00D);
    chk("sim_en1", {mem_rd_en, mem_wr_en}, 2'b01);
    serve(2, 64'h5A5A_0000_5678_0000, 1);
    m1_wr_en = 0;
    @(negedge clk);
    chk("sim_m1_ready", m1_ready, 1);
    tick();

    // continuous contention: strict alternation
    do_reset();
    m0_rd_en = 1; m0_addr = 32'h40;
    m1_rd_en = 1; m1_addr = 32'h80;
    eg = 0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      chk($sformatf("cont_idle_t%0d", t), dbg.state, ST_IDLE);
      tick();
      @(negedge clk);
      chk($sformatf("cont_grant_t%0d", t), grant, eg);
      chk($sformatf("cont_addr_t%0d", t), mem_addr, eg ? 32'h80 : 32'h40);
      r = {$urandom, $urandom};
      serve($urandom_range(1, 4), r, eg);
      @(negedge clk);
      chk($sformatf("cont_done_t%0d", t), dbg.state, ST_DONE);
      tick();
      eg = ~eg;
    end
    clear_inputs();
    tick();

    // vector table
    do_reset();
    for (int v = 0; v < 6; v++) begin
      m0_rd_en = vec[v].m0_rd; m0_wr_en = vec[v].m0_wr; m0_miss = vec[v].m0_ms;
      m0_addr = vec[v].m0_a; m0_wdata = vec[v].m0_wd;
      m1_rd_en = vec[v].m1_rd; m1_wr_en = vec[v].m1_wr; m1_miss = vec[v].m1_ms;
      m1_addr = vec[v].m1_a; m1_wdata = vec[v].m1_wd;
      @(negedge clk);
      chk($sformatf("vec%0d_idle", v), dbg.state, ST_IDLE);
      tick();
      @(negedge clk);
      chk($sformatf("vec%0d_grant", v), grant, vec[v].exp_g);
      chk($sformatf("vec%0d_addr", v), mem_addr, vec[v].exp_a);
      chk($sformatf("vec%0d_wdata", v), mem_wdata, vec[v].exp_wd);
      chk($sformatf("vec%0d_en", v), {mem_rd_en, mem_wr_en, mem_miss},
          {vec[v].exp_rd, vec[v].exp_wr, vec[v].exp_ms});
      serve(vec[v].lat, vec[v].rdata, vec[v].exp_g);
      clear_inputs();
      @(negedge clk);
      chk($sformatf("vec%0d_done", v), dbg.state, ST_DONE);
      tick();
    end

    // watchdog timeout (TIMEOUT=8)
    do_reset();
    m0_rd_en = 1; m0_addr = 32'h1000;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 9) m0_rd_en = 0;
      @(negedge clk);
      chk($sformatf("to_err_c%0d", c), err, (c == 9));
      chk($sformatf("to_state_c%0d", c), dbg.state, (c <= 8) ? ST_BUSY : ST_IDLE);
      chk($sformatf("to_m0_ready_c%0d", c), m0_ready, 0);
    end
    chk("to_grant_idle", grant, 0);
    m1_rd_en = 1; m1_addr = 32'h2000;
    tick();
    serve(2, 64'h7777_0000_0000_0007, 1);
    clear_inputs();
    tick();
    @(negedge clk);
    chk("to_err_sticky", err, 1);
    do_reset();
    @(negedge clk);
    chk("to_err_cleared", err, 0);

    // reset mid-transaction while mem_ready is high
    m0_rd_en = 1; m0_addr = 32'h3000;
    tick();
    serve(1, 64'h8888_0000_0000_0008, 0);
    clear_inputs();
    tick();
    @(negedge clk);
    chk("rmid_ptr_before", dbg.ptr, 1);
    m1_rd_en = 1; m1_addr = 32'hB00;
    tick();
    tick();
    rst = 1; mem_ready = 1; mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    tick();
    rst = 0; clear_inputs();
    @(negedge clk);
    chk("rmid_ready", {m1_ready, m0_ready}, 0);
    chk("rmid_rdata0", m0_rdata, 0);
    chk("rmid_rdata1", m1_rdata, 0);
    chk("rmid_grant", grant, 0);
    chk("rmid_mem_en", {mem_rd_en, mem_wr_en}, 0);
    chk("rmid_state", dbg.state, ST_IDLE);
    chk("rmid_ptr", dbg.ptr, 0);
    tick();
    @(negedge clk);
    chk("rmid_ready_after", {m1_ready, m0_ready}, 0);

    // m1 drops its write while BUSY
    m1_wr_en = 1; m1_addr = 32'hC00;
    tick();
    @(negedge clk);
    chk("drop_wr_busy", mem_wr_en, 1);
    tick();
    m1_wr_en = 0;
    @(negedge clk);
    chk("drop_wr_same_cycle", mem_wr_en, 0);
    chk("drop_still_busy", dbg.state, ST_BUSY);
    tick();
    @(negedge clk);
    chk("drop_idle", dbg.state, ST_IDLE);
    chk("drop_no_ready", m1_ready, 0);
    chk("drop_grant", grant, 0);
    tick();

    chk("leftover_m0", exp0_q.size(), 0);
    chk("leftover_m1", exp1_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
